// File: rtl/sysid_verify_ctrl_if.sv
// Avalon-MM read-only link between the verification controller and the system-ID slave.
interface sysid_verify_ctrl_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/sysid_verify_ctrl.sv
// Reads system ID and build timestamp over Avalon-MM, compares against build-time
// constants with retry/timeout, and latches a pass/fail verdict for boot gating.
module sysid_verify_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h5313_8BC2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 err_code,
  output logic [3:0]                 retry_count,
  output logic [31:0]                id_value,
  output logic [31:0]                ts_value,
  sysid_verify_ctrl_if.master        avm
);

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_RD_TS, S_CHECK, S_RETRY, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic        gap_q, gap_d;
  logic [15:0] tmo_q, tmo_d;
  logic [1:0]  pend_q, pend_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic [1:0]  err_q, err_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;

  // The cycle after the ID capture stays in RD_TS with the strobe low (gap_q).
  always_comb begin
    avm.avm_read    = (state_q == S_RD_ID) || ((state_q == S_RD_TS) && !gap_q);
    avm.avm_address = (state_q == S_RD_TS);
  end

  always_comb begin
    state_d = state_q;
    auto_d  = 1'b0;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    retry_d = retry_q;
    id_d    = id_q;
    ts_d    = ts_q;
    case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          state_d = S_RD_ID;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          err_d   = 2'b00;
          retry_d = '0;
          tmo_d   = '0;
        end
      end
      S_RD_ID: begin
        if (!avm.avm_waitrequest) begin
          id_d    = avm.avm_readdata;
          state_d = S_RD_TS;
          gap_d   = 1'b1;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          pend_d  = 2'b11;
          state_d = S_RETRY;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RD_TS: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (!avm.avm_waitrequest) begin
          ts_d    = avm.avm_readdata;
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          pend_d  = 2'b11;
          state_d = S_RETRY;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_CHECK: begin
        if (id_q != EXPECTED_ID) begin
          pend_d  = 2'b01;
          state_d = S_RETRY;
        end else if (ts_q != EXPECTED_TS) begin
          pend_d  = 2'b10;
          state_d = S_RETRY;
        end else begin
          pend_d  = 2'b00;
          state_d = S_DONE;
        end
      end
      S_RETRY: begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 4'd1;
          tmo_d   = '0;
          state_d = S_RD_ID;
        end else begin
          err_d   = pend_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // pend_q is zero only when the last CHECK matched both words.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (pend_q == 2'b00);
        fail_d  = (pend_q != 2'b00);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      auto_q  <= AUTO_START;
      gap_q   <= 1'b0;
      tmo_q   <= '0;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      retry_q <= '0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      auto_q  <= auto_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_code    = err_q;
  assign retry_count = retry_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// Bench for sysid_verify_ctrl: two instances (retrying/auto-start and single-shot)
// against a scripted slave, checked by an attempt-level reference model.
module tb_sysid_verify_ctrl;
  localparam logic [31:0] EID = 32'h0000_0000;
  localparam logic [31:0] ETS = 32'h5313_8BC2;
  localparam int TMO  = 4;
  localparam int MR_A = 3;
  localparam int MR_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        start_r[2];
  logic        busy_w[2], done_w[2], pass_w[2], fail_w[2];
  logic [1:0]  err_w[2];
  logic [3:0]  rc_w[2];
  logic [31:0] id_w[2], ts_w[2];
  logic        rd_w[2], addr_w[2], wr_w[2];
  logic [31:0] rdata_w[2];

  // Scripted slave: per read index, wait cycles and returned word.
  int          cfg_w[2][16];
  logic [31:0] cfg_d[2][16];
  logic        slv_clr[2];
  logic [3:0]  sidx[2];
  int          scnt[2];
  int          rcyc[2];
  int          abad[2];
  logic        alog[2][16];

  logic [31:0] m_id[2], m_ts[2];
  int checks = 0;
  int errors = 0;

  sysid_verify_ctrl_if bus0 ();
  sysid_verify_ctrl_if bus1 ();

  sysid_verify_ctrl #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(TMO),
                      .MAX_RETRIES(MR_A), .AUTO_START(1'b1)) dut_a (
    .clock(clk), .reset(rst[0]), .start(start_r[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .fail(fail_w[0]), .err_code(err_w[0]), .retry_count(rc_w[0]),
    .id_value(id_w[0]), .ts_value(ts_w[0]), .avm(bus0.master));

  sysid_verify_ctrl #(.EXPECTED_ID(EID), .EXPECTED_TS(ETS), .TIMEOUT_CYCLES(TMO),
                      .MAX_RETRIES(MR_B), .AUTO_START(1'b0)) dut_b (
    .clock(clk), .reset(rst[1]), .start(start_r[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .fail(fail_w[1]), .err_code(err_w[1]), .retry_count(rc_w[1]),
    .id_value(id_w[1]), .ts_value(ts_w[1]), .avm(bus1.master));

  assign rd_w[0]   = bus0.avm_read;
  assign addr_w[0] = bus0.avm_address;
  assign rd_w[1]   = bus1.avm_read;
  assign addr_w[1] = bus1.avm_address;
  assign bus0.avm_waitrequest = wr_w[0];
  assign bus0.avm_readdata    = rdata_w[0];
  assign bus1.avm_waitrequest = wr_w[1];
  assign bus1.avm_readdata    = rdata_w[1];

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      wr_w[g]    = rd_w[g] && (scnt[g] < cfg_w[g][sidx[g]]);
      rdata_w[g] = cfg_d[g][sidx[g]];
    end
  end

  // A read ends either on completion or when the master drops the strobe mid-wait.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (slv_clr[g]) begin
        sidx[g] <= '0;
        scnt[g] <= 0;
        rcyc[g] <= 0;
        abad[g] <= 0;
      end else if (rd_w[g]) begin
        rcyc[g] <= rcyc[g] + 1;
        if (scnt[g] == 0) alog[g][sidx[g]] <= addr_w[g];
        else if (addr_w[g] !== alog[g][sidx[g]]) abad[g] <= abad[g] + 1;
        if (wr_w[g]) scnt[g] <= scnt[g] + 1;
        else begin
          sidx[g] <= sidx[g] + 4'd1;
          scnt[g] <= 0;
        end
      end else if (scnt[g] != 0) begin
        sidx[g] <= sidx[g] + 4'd1;
        scnt[g] <= 0;
      end
    end
  end

  task automatic prep(input int g);
    slv_clr[g] = 1'b1;
    @(negedge clk);
    slv_clr[g] = 1'b0;
  endtask

  task automatic set_plain(input int g, input logic [31:0] idv, input logic [31:0] tsv);
    for (int i = 0; i < 16; i++) begin
      cfg_w[g][i] = 0;
      cfg_d[g][i] = (i % 2 == 0) ? idv : tsv;
    end
  endtask

  // Launches (unless auto) one run, checks timing and verdict against the model.
  task automatic run_check(input int g, input bit auto_go, input string name);
    int idx = 0, cyc = 1, ecyc = 0, rc = 0, pend = 0, mr, lat, busy_bad, bad_addr;
    bit ok = 0, got = 0;
    bit ea[16];
    int poke;
    logic [31:0] eid, ets;
    mr  = (g == 0) ? MR_A : MR_B;
    eid = m_id[g];
    ets = m_ts[g];
    for (int i = 0; i < 16; i++) ea[i] = 1'b0;
    for (int a = 0; a < 16; a++) begin
      pend = 0;
      ea[idx] = 1'b0;
      if (cfg_w[g][idx] >= TMO) begin
        cyc += TMO; ecyc += TMO; idx++; pend = 3;
      end else begin
        cyc += cfg_w[g][idx] + 1; ecyc += cfg_w[g][idx] + 1;
        eid = cfg_d[g][idx]; idx++;
        cyc += 1;
        ea[idx] = 1'b1;
        if (cfg_w[g][idx] >= TMO) begin
          cyc += TMO; ecyc += TMO; idx++; pend = 3;
        end else begin
          cyc += cfg_w[g][idx] + 1; ecyc += cfg_w[g][idx] + 1;
          ets = cfg_d[g][idx]; idx++;
          cyc += 1;
          if (eid != EID) pend = 1;
          else if (ets != ETS) pend = 2;
        end
      end
      if (pend == 0) begin ok = 1; break; end
      cyc += 1;
      if (rc < mr) rc++;
      else break;
    end
    cyc += 1;
    m_id[g] = eid;
    m_ts[g] = ets;

    if (!auto_go) begin
      prep(g);
      start_r[g] = 1'b1;
    end
    poke = $urandom_range(2, 4);
    lat = 0;
    busy_bad = 0;
    while (lat < 400 && !got) begin
      @(negedge clk);
      lat++;
      start_r[g] = (lat == poke);
      if (done_w[g] === 1'b1) got = 1;
      else if (busy_w[g] !== 1'b1) busy_bad++;
    end
    start_r[g] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout got none exp latency %0d", name, cyc);
    end
    checks++; if (lat !== cyc) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, lat, cyc); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL %s busy_low_while_running got %0d exp 0", name, busy_bad); end
    checks++; if (busy_w[g] !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b exp 0", name, busy_w[g]); end
    checks++; if (pass_w[g] !== ok) begin errors++; $display("FAIL %s pass got %b exp %b", name, pass_w[g], ok); end
    checks++; if (fail_w[g] !== !ok) begin errors++; $display("FAIL %s fail got %b exp %b", name, fail_w[g], !ok); end
    checks++; if (err_w[g] !== 2'(ok ? 0 : pend)) begin errors++; $display("FAIL %s err_code got %0d exp %0d", name, err_w[g], ok ? 0 : pend); end
    checks++; if (rc_w[g] !== 4'(rc)) begin errors++; $display("FAIL %s retry_count got %0d exp %0d", name, rc_w[g], rc); end
    checks++; if (id_w[g] !== eid) begin errors++; $display("FAIL %s id_value got %h exp %h", name, id_w[g], eid); end
    checks++; if (ts_w[g] !== ets) begin errors++; $display("FAIL %s ts_value got %h exp %h", name, ts_w[g], ets); end
    checks++; if (sidx[g] !== 4'(idx)) begin errors++; $display("FAIL %s read_count got %0d exp %0d", name, sidx[g], idx); end
    checks++; if (rcyc[g] !== ecyc) begin errors++; $display("FAIL %s read_high_cycles got %0d exp %0d", name, rcyc[g], ecyc); end
    bad_addr = abad[g];
    for (int i = 0; i < idx; i++) if (alog[g][i] !== ea[i]) bad_addr++;
    checks++; if (bad_addr !== 0) begin errors++; $display("FAIL %s address_sequence got %0d bad exp 0", name, bad_addr); end
    @(negedge clk);
    checks++; if (done_w[g] !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width got %b exp 0", name, done_w[g]); end
  endtask

  task automatic test_reset;
    rst[0] = 1'b1; rst[1] = 1'b1;
    start_r[0] = 1'b0; start_r[1] = 1'b0;
    slv_clr[0] = 1'b1; slv_clr[1] = 1'b1;
    set_plain(0, EID, ETS);
    set_plain(1, EID, ETS);
    repeat (3) @(negedge clk);
    slv_clr[0] = 1'b0; slv_clr[1] = 1'b0;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy_w[g], done_w[g], pass_w[g], fail_w[g], err_w[g], rc_w[g], rd_w[g]} !== 11'b0 ||
          id_w[g] !== 32'h0 || ts_w[g] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got busy=%b done=%b pass=%b fail=%b err=%0d rc=%0d rd=%b id=%h ts=%h exp all 0",
                 g, busy_w[g], done_w[g], pass_w[g], fail_w[g], err_w[g], rc_w[g], rd_w[g], id_w[g], ts_w[g]);
      end
      m_id[g] = '0;
      m_ts[g] = '0;
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    run_check(0, 1'b1, "auto_start");
  endtask

  task automatic test_id_mismatch;
    set_plain(0, 32'h0000_0001, ETS);
    run_check(0, 1'b0, "id_mismatch");
  endtask

  task automatic test_ts_retry;
    set_plain(0, EID, ETS);
    cfg_d[0][1] = 32'hDEAD_BEEF;
    run_check(0, 1'b0, "ts_retry");
  endtask

  task automatic test_timeout;
    set_plain(1, EID, ETS);
    for (int i = 0; i < 16; i++) cfg_w[1][i] = 15;
    run_check(1, 1'b0, "timeout");
  endtask

  task automatic test_ts_wait;
    set_plain(0, EID, ETS);
    cfg_w[0][1] = 3;
    run_check(0, 1'b0, "ts_wait3");
  endtask

  task automatic test_reset_mid;
    int n = 0;
    set_plain(1, EID, ETS);
    cfg_w[1][1] = 3;
    prep(1);
    start_r[1] = 1'b1;
    @(negedge clk);
    start_r[1] = 1'b0;
    while (n < 20 && !(rd_w[1] === 1'b1 && addr_w[1] === 1'b1)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL mid_reset reach_rd_ts got none exp ts read"); end
    rst[1] = 1'b1;
    @(negedge clk);
    checks++; if (rd_w[1] !== 1'b0) begin errors++; $display("FAIL mid_reset avm_read got %b exp 0", rd_w[1]); end
    checks++; if (busy_w[1] !== 1'b0) begin errors++; $display("FAIL mid_reset busy got %b exp 0", busy_w[1]); end
    checks++; if (id_w[1] !== 32'h0) begin errors++; $display("FAIL mid_reset id_value got %h exp 0", id_w[1]); end
    m_id[1] = '0;
    m_ts[1] = '0;
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_w[1] !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy got %b exp 0", busy_w[1]); end
    set_plain(1, EID, ETS);
    run_check(1, 1'b0, "after_reset");
  endtask

  task automatic test_random;
    int r;
    for (int it = 0; it < 30; it++) begin
      int g = it % 2;
      for (int i = 0; i < 16; i++) begin
        r = $urandom_range(0, 19);
        cfg_w[g][i] = (r < 12) ? 0 : (r < 18) ? $urandom_range(1, 3) : $urandom_range(4, 6);
        r = $urandom_range(0, 19);
        if (r < 16) cfg_d[g][i] = (i % 2 == 0) ? EID : ETS;
        else if (r < 18) cfg_d[g][i] = (i % 2 == 0) ? ETS : EID;
        else cfg_d[g][i] = $urandom;
      end
      run_check(g, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_id_mismatch;
    test_ts_retry;
    test_timeout;
    test_ts_wait;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
